ifft8_engine: RTL and testbench

IFFT8_ENGINE -- requirements
Module: ifft8_engine

---
 rtl/fft_pkg.sv | 49 ++++
 rtl/ifft_butterfly.sv | 71 +++++++
 rtl/ifft8_engine.sv | 201 ++++++++++++++++++++
 tb/tb_ifft8_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the 8-point inverse FFT engine.
//   DW, TW      default sample width and twiddle width (Q1.10 twiddles)
//   N           transform length
//   state_t     engine FSM states
//   tw_re/tw_im conjugated (inverse-direction) twiddles, indices 0..3
//   bitrev3     3-bit bit reversal used for the DIT input permutation
// ----------------------------------------------------------------------------
package fft_pkg;

    localparam int DW      = 12;
    localparam int TW      = 12;
    localparam int N       = 8;
    localparam int Q_SHIFT = 10;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // Real part of e^(+j*2*pi*idx/8) in Q1.10.
    function automatic logic signed [TW-1:0] tw_re(input logic [1:0] idx);
        case (idx)
            2'd0:    tw_re = 12'sd1024;
            2'd1:    tw_re = 12'sd724;
            2'd2:    tw_re = 12'sd0;
            2'd3:    tw_re = -12'sd724;
            default: tw_re = 12'sd0;
        endcase
    endfunction

    // Imaginary part of e^(+j*2*pi*idx/8) in Q1.10.
    function automatic logic signed [TW-1:0] tw_im(input logic [1:0] idx);
        case (idx)
            2'd0:    tw_im = 12'sd0;
            2'd1:    tw_im = 12'sd724;
            2'd2:    tw_im = 12'sd1024;
            2'd3:    tw_im = 12'sd724;
            default: tw_im = 12'sd0;
        endcase
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] a);
        bitrev3 = {a[0], a[1], a[2]};
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// ----------------------------------------------------------------------------
// ifft_butterfly
// Combinational radix-2 DIT butterfly with per-stage halving and saturation.
//   x1_*, x2_*  input pair (x2 is the twiddled leg)
//   w_r, w_i    twiddle, Q1.10
//   y1_*        sat((x1 + x2*w) >>> 1)
//   y2_*        sat((x1 - x2*w) >>> 1)
// Truncating arithmetic throughout; no rounding.
// ----------------------------------------------------------------------------
module ifft_butterfly #(
    parameter int DW = fft_pkg::DW,
    parameter int TW = fft_pkg::TW
) (
    input  logic signed [DW-1:0] x1_r,
    input  logic signed [DW-1:0] x1_i,
    input  logic signed [DW-1:0] x2_r,
    input  logic signed [DW-1:0] x2_i,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    output logic signed [DW-1:0] y1_r,
    output logic signed [DW-1:0] y1_i,
    output logic signed [DW-1:0] y2_r,
    output logic signed [DW-1:0] y2_i
);
    import fft_pkg::*;

    localparam int PW = DW + TW;   // full product width
    localparam int SW = DW + 2;    // sum width, holds |x1| + |t| without wrap

    localparam int SMAX_I = (32'sd1 <<< (DW - 1)) - 32'sd1;
    localparam int SMIN_I = -(32'sd1 <<< (DW - 1));
    localparam logic signed [SW-1:0] SMAX = SW'(SMAX_I);
    localparam logic signed [SW-1:0] SMIN = SW'(SMIN_I);

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX) begin
            sat = SMAX[DW-1:0];
        end else if (v < SMIN) begin
            sat = SMIN[DW-1:0];
        end else begin
            sat = v[DW-1:0];
        end
    endfunction

    logic signed [PW-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
    logic signed [PW:0]   t_r_w_s, t_i_w_s;
    logic signed [SW-1:0] t_r_s, t_i_s;
    logic signed [SW-1:0] s_r_s, s_i_s, d_r_s, d_i_s;

    // Complex multiply, Q1.10 rescale, then halved sum/difference with clamp.
    always_comb begin
        p_rr_s  = PW'(x2_r) * PW'(w_r);
        p_ii_s  = PW'(x2_i) * PW'(w_i);
        p_ri_s  = PW'(x2_r) * PW'(w_i);
        p_ir_s  = PW'(x2_i) * PW'(w_r);
        t_r_w_s = ((PW + 1)'(p_rr_s) - (PW + 1)'(p_ii_s)) >>> Q_SHIFT;
        t_i_w_s = ((PW + 1)'(p_ri_s) + (PW + 1)'(p_ir_s)) >>> Q_SHIFT;
        // |t| <= sqrt(2) * 2^(DW-1), so the low SW bits carry it exactly.
        t_r_s   = t_r_w_s[SW-1:0];
        t_i_s   = t_i_w_s[SW-1:0];
        s_r_s   = SW'(x1_r) + t_r_s;
        s_i_s   = SW'(x1_i) + t_i_s;
        d_r_s   = SW'(x1_r) - t_r_s;
        d_i_s   = SW'(x1_i) - t_i_s;
        y1_r    = sat(s_r_s >>> 2'd1);
        y1_i    = sat(s_i_s >>> 2'd1);
        y2_r    = sat(d_r_s >>> 2'd1);
        y2_i    = sat(d_i_s >>> 2'd1);
    end

endmodule

// File: rtl/ifft8_engine.sv
// ----------------------------------------------------------------------------
// ifft8_engine
// 8-point inverse FFT, radix-2 DIT, in place over a register buffer.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     frequency bins X[0..7], natural order (in_r, in_i)
//   in_last               marks bin 7, not used for sequencing
//   out_valid/out_ready   time samples x[0..7], natural order (out_r, out_i)
//   out_last              high with x[7]
// LOAD (8 beats, bit-reversed writes) -> COMPUTE (12 butterflies) -> UNLOAD.
// ----------------------------------------------------------------------------
module ifft8_engine #(
    parameter int DW = fft_pkg::DW,
    parameter int TW = fft_pkg::TW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 out_last
);
    import fft_pkg::*;

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r;
    logic                cnt_adv_s;
    logic                in_ready_r, out_valid_r, out_last_r;
    logic signed [DW-1:0] out_r_r, out_i_r;
    logic signed [DW-1:0] bufr_r [N];
    logic signed [DW-1:0] bufi_r [N];
    logic                in_fire_s, out_fire_s;
    logic [1:0]          stage_s, bfly_s, widx_s;
    logic [2:0]          a1_s, a2_s;
    logic signed [TW-1:0] w_r_s, w_i_s;
    logic signed [DW-1:0] y1_r_s, y1_i_s, y2_r_s, y2_i_s;
    logic                unused_s;

    assign unused_s = in_last;

    // Handshakes, next state and counter advance.
    always_comb begin
        in_fire_s   = in_valid && in_ready_r;
        out_fire_s  = out_valid_r && out_ready;
        state_nxt_s = state_r;
        cnt_adv_s   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                cnt_adv_s = in_fire_s;
                if (in_fire_s && (cnt_r == 4'd7)) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                cnt_adv_s = 1'b1;
                if (cnt_r == 4'd11) begin
                    state_nxt_s = ST_UNLOAD;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_UNLOAD: begin
                cnt_adv_s = out_fire_s;
                if (out_fire_s && (cnt_r == 4'd7)) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                cnt_adv_s   = 1'b0;
            end
        endcase
    end

    // Butterfly addressing: cnt = {stage, butterfly}; pair span is 2^stage,
    // twiddle index is (j mod 2^s) * 2^(2-s).
    always_comb begin
        stage_s = cnt_r[3:2];
        bfly_s  = cnt_r[1:0];
        case (stage_s)
            2'd0: begin
                a1_s   = {bfly_s, 1'b0};
                a2_s   = {bfly_s, 1'b1};
                widx_s = 2'd0;
            end
            2'd1: begin
                a1_s   = {bfly_s[1], 1'b0, bfly_s[0]};
                a2_s   = {bfly_s[1], 1'b1, bfly_s[0]};
                widx_s = {bfly_s[0], 1'b0};
            end
            2'd2: begin
                a1_s   = {1'b0, bfly_s};
                a2_s   = {1'b1, bfly_s};
                widx_s = bfly_s;
            end
            default: begin
                a1_s   = 3'd0;
                a2_s   = 3'd0;
                widx_s = 2'd0;
            end
        endcase
        w_r_s = TW'(tw_re(widx_s));
        w_i_s = TW'(tw_im(widx_s));
    end

    ifft_butterfly #(.DW(DW), .TW(TW)) u_bfly (
        .x1_r (bufr_r[a1_s]),
        .x1_i (bufi_r[a1_s]),
        .x2_r (bufr_r[a2_s]),
        .x2_i (bufi_r[a2_s]),
        .w_r  (w_r_s),
        .w_i  (w_i_s),
        .y1_r (y1_r_s),
        .y1_i (y1_i_s),
        .y2_r (y2_r_s),
        .y2_i (y2_i_s)
    );

    // FSM state, shared beat/butterfly counter and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_LOAD;
            cnt_r      <= 4'd0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_LOAD);
            if (state_nxt_s != state_r) begin
                cnt_r <= 4'd0;
            end else if (cnt_adv_s) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Sample buffer: bit-reversed loads, then in-place butterfly writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                bufr_r[k] <= '0;
                bufi_r[k] <= '0;
            end
        end else if ((state_r == ST_LOAD) && in_fire_s) begin
            bufr_r[bitrev3(cnt_r[2:0])] <= in_r;
            bufi_r[bitrev3(cnt_r[2:0])] <= in_i;
        end else if (state_r == ST_COMPUTE) begin
            bufr_r[a1_s] <= y1_r_s;
            bufi_r[a1_s] <= y1_i_s;
            bufr_r[a2_s] <= y2_r_s;
            bufi_r[a2_s] <= y2_i_s;
        end
    end

    // Output register: first UNLOAD cycle fetches x[0], each accepted beat
    // fetches the next sample; stalled beats hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_r_r     <= '0;
            out_i_r     <= '0;
        end else if (state_r == ST_UNLOAD) begin
            if (!out_valid_r) begin
                out_valid_r <= 1'b1;
                out_r_r     <= bufr_r[cnt_r[2:0]];
                out_i_r     <= bufi_r[cnt_r[2:0]];
                out_last_r  <= (cnt_r == 4'd7);
            end else if (out_ready) begin
                if (cnt_r == 4'd7) begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end else begin
                    out_r_r    <= bufr_r[cnt_r[2:0] + 3'd1];
                    out_i_r    <= bufi_r[cnt_r[2:0] + 3'd1];
                    out_last_r <= (cnt_r == 4'd6);
                end
            end
        end else begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_r     = out_r_r;
    assign out_i     = out_i_r;

endmodule

// File: tb/tb_ifft8_engine.sv
// ----------------------------------------------------------------------------
// tb_ifft8_engine
// Self-checking bench: directed vector table with tolerances, a fixed-point
// reference IDFT built from the arithmetic rules, randomized frames with
// random output backpressure, a latency check and a mid-COMPUTE reset.
// ----------------------------------------------------------------------------
module tb_ifft8_engine;

    localparam int DW = 12;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 out_last;

    ifft8_engine #(.DW(DW), .TW(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic [7:0][15:0] er;
        logic [7:0][15:0] ei;
        logic [3:0]       tol;
    } vec_t;

    vec_t vecs [4];

    int checks = 0;
    int errors = 0;
    int fr_r [8], fr_i [8];
    int md_r [8], md_i [8];
    int got_r [8], got_i [8];
    bit junk = 1'b0;

    int wtab_r [4] = '{1024, 724, 0, -724};
    int wtab_i [4] = '{0, 724, 1024, 724};
    int tone_er [8] = '{128, 90, 0, -90, -128, -90, 0, 90};
    int tone_ei [8] = '{0, 90, 128, 90, 0, -90, -128, -90};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int brev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // Reference: radix-2 DIT IDFT in plain integer arithmetic.
    task automatic run_model();
        int ar [8], ai [8];
        int h, p, q, idx, tr, ti, x1r, x1i;
        for (int k = 0; k < 8; k++) begin
            ar[brev(k)] = fr_r[k];
            ai[brev(k)] = fr_i[k];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int base = 0; base < 8; base += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    p   = base + j;
                    q   = p + h;
                    idx = j * (4 >> s);
                    tr  = (ar[q] * wtab_r[idx] - ai[q] * wtab_i[idx]) >>> 10;
                    ti  = (ar[q] * wtab_i[idx] + ai[q] * wtab_r[idx]) >>> 10;
                    x1r = ar[p];
                    x1i = ai[p];
                    ar[p] = clamp((x1r + tr) >>> 1);
                    ai[p] = clamp((x1i + ti) >>> 1);
                    ar[q] = clamp((x1r - tr) >>> 1);
                    ai[q] = clamp((x1i - ti) >>> 1);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            md_r[k] = ar[k];
            md_i[k] = ai[k];
        end
    endtask

    task automatic send_frame();
        int guard;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_r     = 12'(fr_r[k]);
            in_i     = 12'(fr_i[k]);
            in_last  = (k == 7);
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 100) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_last  = 1'b0;
        in_valid = junk;
        in_r     = 12'($urandom_range(4095, 0));
        in_i     = 12'($urandom_range(4095, 0));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready.
    task automatic recv_frame(input int mode);
        int n, cyc, hr, hi, hl;
        bit rdy, tog;
        n = 0; cyc = 0; tog = 1'b1;
        while (n < 8 && cyc < 500) begin
            chk("valid_held", int'(out_valid), 1);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = tog;
            else                rdy = 1'($urandom_range(1, 0));
            tog = ~tog;
            out_ready = rdy;
            if (rdy && n == 7) in_valid = 1'b0;
            hr = out_r; hi = out_i; hl = int'(out_last);
            if (rdy) begin
                got_r[n] = out_r;
                got_i[n] = out_i;
                chk("out_last", int'(out_last), int'(n == 7));
                n++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!rdy) begin
                chk("stall_r", int'(out_r), hr);
                chk("stall_i", int'(out_i), hi);
                chk("stall_last", int'(out_last), hl);
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (n < 8) chk("unload_timeout", n, 8);
        chk("valid_after", int'(out_valid), 0);
        chk("ready_after", int'(in_ready), 1);
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 8; k++) begin
            chk("model_r", got_r[k], md_r[k]);
            chk("model_i", got_i[k], md_i[k]);
        end
    endtask

    initial begin
        int lat;
        vec_t v;

        rst_n = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0;
        in_last = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 4; i++) begin
            vecs[i] = '0;
        end
        vecs[0].xr[0] = 16'sd1024;
        vecs[1].xr[0] = 16'sd800;
        vecs[1].xi[0] = -16'sd400;
        vecs[2].xr[1] = 16'sd1024;
        vecs[2].tol   = 4'd2;
        vecs[3].tol   = 4'd2;
        vecs[3].er[0] = 16'sd2047;
        vecs[3].ei[0] = 16'sd2047;
        for (int k = 0; k < 8; k++) begin
            vecs[0].er[k] = 16'sd128;
            vecs[1].er[k] = 16'sd100;
            vecs[1].ei[k] = -16'sd50;
            vecs[2].er[k] = 16'(tone_er[k]);
            vecs[2].ei[k] = 16'(tone_ei[k]);
            vecs[3].xr[k] = 16'sd2047;
            vecs[3].xi[k] = 16'sd2047;
        end

        #22;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_out_i", int'(out_i), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed vectors: impulse, DC (with 1010 backpressure), tone
        // (with ignored in_valid traffic), saturation.
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            for (int k = 0; k < 8; k++) begin
                fr_r[k] = int'($signed(v.xr[k]));
                fr_i[k] = int'($signed(v.xi[k]));
            end
            run_model();
            junk = (i == 2);
            send_frame();
            wait_out(lat);
            if (i == 0) chk("latency", lat, 13);
            recv_frame((i == 1) ? 1 : 0);
            junk = 1'b0;
            for (int k = 0; k < 8; k++) begin
                chk_tol("vec_r", got_r[k], int'($signed(v.er[k])), int'(v.tol));
                chk_tol("vec_i", got_i[k], int'($signed(v.ei[k])), int'(v.tol));
            end
            cmp_model();
        end

        // Reset in the middle of COMPUTE, then a clean impulse frame.
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = int'($urandom_range(4095, 0)) - 2048;
            fr_i[k] = int'($urandom_range(4095, 0)) - 2048;
        end
        send_frame();
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_last", int'(out_last), 0);
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int k = 0; k < 8; k++) begin
            fr_r[k] = (k == 0) ? 1024 : 0;
            fr_i[k] = 0;
        end
        run_model();
        send_frame();
        wait_out(lat);
        recv_frame(0);
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_r", got_r[k], 128);
            chk("post_rst_i", got_i[k], 0);
        end

        // Randomized frames against the reference, random backpressure.
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f < 2) begin
                    fr_r[k] = ($urandom_range(1, 0) != 0) ? 2047 : -2048;
                    fr_i[k] = ($urandom_range(1, 0) != 0) ? 2047 : -2048;
                end else begin
                    fr_r[k] = int'($urandom_range(4095, 0)) - 2048;
                    fr_i[k] = int'($urandom_range(4095, 0)) - 2048;
                end
            end
            run_model();
            junk = (f[0] == 1'b1);
            send_frame();
            wait_out(lat);
            chk("rand_latency", lat, 13);
            recv_frame(2);
            junk = 1'b0;
            cmp_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
